// File: rtl/multi_chan_dbuf_reg.sv
// Double-buffered multi-channel register bank: per-channel staging registers feed
// active registers that update together on an external or periodic commit event.
module multi_chan_dbuf_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      NCH     = 2,
  parameter int unsigned      PERIOD  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       wr_en,
  input  logic [NCH*WIDTH-1:0] wr_data,
  input  logic                 commit,
  input  logic                 auto_en,
  output logic [NCH*WIDTH-1:0] q,
  output logic [NCH-1:0]       pending,
  output logic                 upd,
  output logic [7:0]           commit_cnt
);

  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);

  logic [WIDTH-1:0] stage_q  [NCH];
  logic [WIDTH-1:0] stage_d  [NCH];
  logic [WIDTH-1:0] active_q [NCH];
  logic [WIDTH-1:0] active_d [NCH];
  logic [NCH-1:0]   pending_q, pending_d;
  logic             upd_q, upd_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic tick;
  logic ce;
  logic eff_commit;

  assign tick       = auto_en && (timer_q == TIMER_LAST);
  assign ce         = commit || tick;
  assign eff_commit = ce && (|pending_q);

  // An external commit restarts the auto-commit interval.
  always_comb begin
    timer_d = timer_q;
    if (commit || !auto_en) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Commit moves the old staged value; a same-edge write re-arms pending (set wins).
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stage_d[i]   = stage_q[i];
      active_d[i]  = active_q[i];
      pending_d[i] = pending_q[i];
      if (ce && pending_q[i]) begin
        active_d[i]  = stage_q[i];
        pending_d[i] = 1'b0;
      end
      if (wr_en[i]) begin
        stage_d[i]   = wr_data[i*WIDTH +: WIDTH];
        pending_d[i] = 1'b1;
      end
    end
  end

  // upd is a single-cycle pulse following each effective commit; no handshake back.
  always_comb begin
    upd_d = eff_commit;
    cnt_d = eff_commit ? (cnt_q + 8'd1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        stage_q[i]  <= RST_VAL;
        active_q[i] <= RST_VAL;
      end
      pending_q <= '0;
      upd_q     <= 1'b0;
      cnt_q     <= 8'd0;
      timer_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        stage_q[i]  <= stage_d[i];
        active_q[i] <= active_d[i];
      end
      pending_q <= pending_d;
      upd_q     <= upd_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_q
    assign q[g*WIDTH +: WIDTH] = active_q[g];
  end

  assign pending    = pending_q;
  assign upd        = upd_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_multi_chan_dbuf_reg.sv
// Bench for multi_chan_dbuf_reg: directed scenarios plus random traffic, every cycle
// compared against a behavioural model through an expected-output queue.
module tb_multi_chan_dbuf_reg;

  localparam int W      = 8;
  localparam int NCH    = 2;
  localparam int PERIOD = 4;
  localparam logic [W-1:0] RST_VAL = 8'h00;
  localparam int EW     = NCH*W + NCH + 1 + 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     wr_en;
  logic [NCH*W-1:0]   wr_data;
  logic               commit;
  logic               auto_en;
  logic [NCH*W-1:0]   q;
  logic [NCH-1:0]     pending;
  logic               upd;
  logic [7:0]         commit_cnt;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state
  logic [W-1:0] m_stage  [NCH];
  logic [W-1:0] m_active [NCH];
  logic [NCH-1:0] m_pend;
  logic m_upd;
  int   m_cnt;
  int   m_timer;

  multi_chan_dbuf_reg #(
    .WIDTH(W), .NCH(NCH), .PERIOD(PERIOD), .RST_VAL(RST_VAL)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .commit(commit),
    .auto_en(auto_en), .q(q), .pending(pending), .upd(upd), .commit_cnt(commit_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [NCH*W-1:0] model_q();
    logic [NCH*W-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*W +: W] = m_active[i];
    return v;
  endfunction

  // Model of one clock edge from the pre-edge state and inputs
  task automatic model_step(input logic r, input logic [NCH-1:0] we,
                            input logic [NCH*W-1:0] wd, input logic cm, input logic ae);
    bit tick, ce, eff;
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_stage[i]  = RST_VAL;
        m_active[i] = RST_VAL;
      end
      m_pend = '0; m_upd = 1'b0; m_cnt = 0; m_timer = 0;
    end else begin
      tick = ae && (m_timer == PERIOD-1);
      ce   = cm || tick;
      eff  = ce && (m_pend != 0);
      for (int i = 0; i < NCH; i++) begin
        if (ce && m_pend[i]) m_active[i] = m_stage[i];
        if (we[i]) m_stage[i] = wd[i*W +: W];
      end
      m_pend  = we | (ce ? '0 : m_pend);
      m_upd   = eff;
      m_cnt   = (m_cnt + (eff ? 1 : 0)) % 256;
      m_timer = (cm || !ae) ? 0 : (m_timer + 1) % PERIOD;
    end
  endtask

  // Driver: apply inputs, take one edge, push the model's expected outputs
  task automatic cycle(input logic r, input logic [NCH-1:0] we,
                       input logic [NCH*W-1:0] wd, input logic cm, input logic ae);
    rst = r; wr_en = we; wr_data = wd; commit = cm; auto_en = ae;
    @(posedge clk);
    model_step(r, we, wd, cm, ae);
    exp_q.push_back({model_q(), m_pend, m_upd, 8'(m_cnt)});
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({q, pending, upd, commit_cnt} !== e) begin
        errors++;
        $display("FAIL outputs @%0t: q=%h pending=%b upd=%b cnt=%0d expected q=%h pending=%b upd=%b cnt=%0d",
                 $time, q, pending, upd, commit_cnt,
                 e[EW-1 -: NCH*W], e[8+1 +: NCH], e[8], e[7:0]);
      end
    end
  end

  initial begin
    int cnt_ref;
    logic ae;
    rst = 1'b1; wr_en = '0; wr_data = '0; commit = 1'b0; auto_en = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_stage[i] = RST_VAL; m_active[i] = RST_VAL;
    end
    m_pend = '0; m_upd = 1'b0; m_cnt = 0; m_timer = 0;

    // Reset overrides writes and commit
    cycle(1, 2'b11, 16'hFFFF, 1, 0);
    cycle(1, 2'b11, 16'hFFFF, 1, 0);
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_pend_upd_cnt", {22'd0, pending, upd, commit_cnt}, 32'h0);

    // Staged then commit
    cycle(0, 2'b11, 16'h0001, 0, 0);
    chk("staged_q_hold", 32'(q), 32'h0);
    chk("staged_pending", 32'(pending), 32'h3);
    cycle(0, 2'b00, 16'h0000, 1, 0);
    chk("commit_q", 32'(q), 32'h0001);
    chk("commit_upd_cnt", {22'd0, pending, upd, commit_cnt}, {22'd0, 2'b00, 1'b1, 8'd1});
    cycle(0, 2'b00, 16'h0000, 0, 0);
    chk("upd_one_cycle", 32'(upd), 32'h0);

    // Partial update
    cycle(0, 2'b11, 16'hAA55, 0, 0);
    cycle(0, 2'b00, 16'h0000, 1, 0);
    cycle(0, 2'b10, 16'h0F00, 0, 0);
    cycle(0, 2'b00, 16'h0000, 1, 0);
    chk("partial_q", 32'(q), 32'h0F55);

    // Write/commit collision
    cycle(0, 2'b01, 16'h0011, 0, 0);
    cycle(0, 2'b01, 16'h0022, 1, 0);
    chk("collide_q", 32'(q[7:0]), 32'h11);
    chk("collide_pending", 32'(pending[0]), 32'h1);
    cycle(0, 2'b00, 16'h0000, 1, 0);
    chk("collide_next_q", 32'(q[7:0]), 32'h22);
    chk("collide_cnt", 32'(commit_cnt), 32'd5);

    // Auto-commit on the 4th edge after auto_en rises
    cycle(0, 2'b01, 16'h0033, 0, 1);
    cycle(0, 2'b00, 16'h0000, 0, 1);
    cycle(0, 2'b00, 16'h0000, 0, 1);
    chk("auto_before", 32'(q[7:0]), 32'h22);
    cycle(0, 2'b00, 16'h0000, 0, 1);
    chk("auto_q", 32'(q[7:0]), 32'h33);
    chk("auto_upd_cnt", {23'd0, upd, commit_cnt}, {23'd0, 1'b1, 8'd6});

    // Empty commit
    cycle(0, 2'b00, 16'h0000, 1, 0);
    chk("empty_upd_cnt", {23'd0, upd, commit_cnt}, {23'd0, 1'b0, 8'd6});

    // External commit restarts the interval
    cycle(0, 2'b10, 16'h4400, 0, 1);
    cycle(0, 2'b00, 16'h0000, 1, 1);
    chk("ext_commit_q", 32'(q[15:8]), 32'h44);
    cycle(0, 2'b10, 16'h5500, 0, 1);
    cycle(0, 2'b00, 16'h0000, 0, 1);
    cycle(0, 2'b00, 16'h0000, 0, 1);
    chk("restart_hold", 32'(q[15:8]), 32'h44);
    cycle(0, 2'b00, 16'h0000, 0, 1);
    chk("restart_commit", 32'(q[15:8]), 32'h55);

    // 256 effective commits wrap the counter back to its starting value
    cnt_ref = m_cnt;
    cycle(0, 2'b01, 16'(($urandom & 32'hFF)), 0, 0);
    for (int k = 0; k < 256; k++)
      cycle(0, 2'b01, 16'(($urandom & 32'hFF)), 1, 0);
    chk("cnt_wrap", 32'(commit_cnt), 32'(cnt_ref));
    cycle(0, 2'b00, 16'h0000, 1, 0);

    // Mid-op reset discards staged data
    cycle(0, 2'b01, 16'h0077, 0, 0);
    cycle(1, 2'b00, 16'h0000, 0, 0);
    cycle(0, 2'b00, 16'h0000, 1, 0);
    chk("midreset_q", 32'(q), 32'(RST_VAL));
    chk("midreset_upd", 32'(upd), 32'h0);

    // Random traffic
    ae = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 15) == 0) ae = ~ae;
      cycle(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), 16'($urandom),
            ($urandom_range(0, 3) == 0), ae);
    end

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_chan_dbuf_reg.md
Name: multi_chan_dbuf_reg

Overview:
Parametrised, double-buffered register bank, generalising the twin 8-bit register to NCH channels of WIDTH bits. Each channel has a staging register written independently and an active register that drives the output. Staged values move to the outputs atomically on a commit event. A commit event comes from an external strobe or from an internal periodic auto-commit timer. The block gives glitch-free, coherent multi-channel updates, such as coefficient or configuration sets.

Parameters:
WIDTH, 8, data width per channel (>=1)
NCH, 2, number of channels (>=1)
PERIOD, 4, auto-commit interval in clock cycles (>=2)
RST_VAL, 0, reset value of every staging and active register (WIDTH bits)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  NCH  per-channel staging write enable; bit i selects channel i
wr_data  input  NCH*WIDTH  flattened write data; channel i = bits [i*WIDTH +: WIDTH]
commit  input  1  external commit strobe, single cycle
auto_en  input  1  enables the periodic auto-commit timer
q  output  NCH*WIDTH  flattened active-register outputs, registered
pending  output  NCH  bit i = 1 when channel i holds a staged value that is not yet committed
upd  output  1  one-cycle pulse: asserted the cycle after a commit that updated at least one channel
commit_cnt  output  8  count of effective commits (upd pulses), wraps 255->0

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - all staging and active registers <= RST_VAL; q = RST_VAL in every slice
  - pending=0, upd=0, commit_cnt=0, timer=0
  - rst overrides every other input in that cycle
- Staging write: on an edge with wr_en[i]=1, stage[i] <= wr_data slice i and pending[i] <= 1. Re-writing before a commit overwrites stage[i]; only the last value is committed.
- Auto timer:
  - counts 0..PERIOD-1 while auto_en=1; tick = (timer==PERIOD-1) & auto_en; wraps to 0 after PERIOD-1
  - held at 0 while auto_en=0
  - forced to 0 on any cycle with commit=1, so an external commit restarts the interval
- Commit event: ce = commit | tick. On an edge with ce=1:
  - for each i with pending[i]=1: active[i] <= stage[i] and pending[i] <= 0
  - channels with pending[i]=0 hold their active value
- Simultaneous wr_en[i] and ce on the same edge:
  - active[i] takes the OLD stage[i] if pending[i] was 1, otherwise it holds
  - stage[i] takes the new wr_data and pending[i] ends at 1 (set wins over clear)
- Effective commit: ce=1 with |pending=1 (pending sampled before the edge).
  - upd=1 for exactly the cycle after that edge
  - commit_cnt increments on that same edge
  - ce with no pending channels: no q change, upd stays 0, no count
- Latency:
  - write to q: minimum 2 edges (write edge N, commit edge N+1; q valid after edge N+1)
  - commit to q: 1 edge
  - q never changes except on an effective commit or on reset
- Reset mid-operation: staged-but-uncommitted data is discarded; pending is cleared.
- Consecutive commits on back-to-back cycles are legal; each is evaluated independently.

Test Plan:
- Reset: rst=1 for 2 cycles with wr_en=2'b11, commit=1 -> q=16'h0000, pending=00, upd=0, commit_cnt=0 throughout.
- Staged then commit (WIDTH=8, NCH=2): write ch0=8'h01, ch1=8'h00 with commit low -> q holds 0, pending=11; pulse commit -> q={8'h00,8'h01}, pending=00, upd=1 for one cycle, commit_cnt=1.
- Partial update: q={8'hAA,8'h55}; write only ch1=8'h0F then commit -> q={8'h0F,8'h55}; ch0 unchanged.
- Write/commit collision: ch0 staged 8'h11 (pending); same edge wr_en[0]=1 with 8'h22 and commit=1 -> q ch0=8'h11, pending[0]=1; next commit -> q ch0=8'h22.
- Auto-commit (PERIOD=4): auto_en=1, stage ch0 8'h33 -> q updates on the 4th edge after auto_en rises, upd pulses, commit_cnt increments. Empty commit (commit=1 with pending=00) -> no upd, count unchanged. External commit mid-interval restarts the 4-cycle period.
- Counter wrap and mid-op reset: perform 256 effective commits -> commit_cnt wraps to 0. Stage 8'h77, assert rst, then commit -> q=RST_VAL, upd=0.
